// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte loader and the memory write port.
// State encodings, frame layout constants and the bus widths used on both sides.
package imem_loader_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int LEN_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length/payload/checksum frame from a valid/ready
// byte channel, writes the payload into instruction memory and stalls the core meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int HEIGHT    = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [WORD_W-1:0] MAX_LEN       = WORD_W'(HEIGHT - BASE_ADDR);
    localparam logic [WORD_W-1:0] BASE          = WORD_W'(BASE_ADDR);
    localparam logic [1:0]        LAST_LEN_BYTE = 2'(LEN_BYTES - 1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] len;
    logic [WORD_W-1:0] idx;
    logic [BYTE_W-1:0] sum;

    logic              beat;
    logic              restart;
    logic [WORD_W-1:0] len_full;
    logic [BYTE_W-1:0] csum_total;

    // Handshake and status are pure state decodes so rx_ready never depends on rx_valid.
    assign rx_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);
    assign cpu_hold = (state != ST_IDLE);

    assign beat       = rx_valid && rx_ready;
    assign restart    = start && ((state == ST_IDLE) || (state == ST_ERR));
    assign len_full   = {rx_data, len[WORD_W-1:BYTE_W]};
    assign csum_total = sum + rx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_LEN;
            end
            ST_LEN: begin
                if (beat && (byte_cnt == LAST_LEN_BYTE)) begin
                    if (len_full > MAX_LEN)        state_nx = ST_ERR;
                    else if (len_full == '0)       state_nx = ST_CSUM;
                    else                           state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat && (idx == len - 1'b1)) state_nx = ST_CSUM;
            end
            ST_CSUM: begin
                if (beat) state_nx = (csum_total == '0) ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_nx = ST_IDLE;
            ST_ERR: begin
                if (start) state_nx = ST_LEN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Length is shifted in from the top so the first byte lands in len[7:0].
    // Write port is registered: a payload beat shows up as a write on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            len      <= '0;
            idx      <= '0;
            sum      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                byte_cnt <= '0;
                len      <= '0;
                idx      <= '0;
                sum      <= '0;
            end else if (beat) begin
                case (state)
                    ST_LEN: begin
                        len      <= len_full;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    ST_DATA: begin
                        mem_we   <= 1'b1;
                        mem_addr <= BASE + idx;
                        mem_data <= rx_data;
                        idx      <= idx + 1'b1;
                        sum      <= csum_total;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
